// File: rtl/psum_output_packer_pkg.sv
// psum_output_packer shared definitions:
// FSM encoding, register field positions, saturation bounds.
package psum_output_packer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int CTRL_START    = 0;
  localparam int CTRL_RELU     = 1;
  localparam int CTRL_SHIFT_LO = 8;
  localparam int SHIFT_W       = 5;

  localparam int STAT_BUSY   = 0;
  localparam int STAT_DONE   = 1;
  localparam int STAT_CNT_LO = 16;
  localparam int STAT_CNT_W  = 16;

  localparam int SAT_U_MAX = 255;
  localparam int SAT_S_MAX = 127;
  localparam int SAT_S_MIN = -128;

endpackage

// File: rtl/psum_output_packer_requant.sv
// Combinational psum requantiser:
// optional ReLU, round-half-up arithmetic shift, 8-bit saturation.
module psum_output_packer_requant
  import psum_output_packer_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int BIT_WIDTH  = 8
) (
  input  logic [DATA_WIDTH-1:0] psum_i,
  input  logic                  relu_i,
  input  logic [SHIFT_W-1:0]    shift_i,
  output logic [BIT_WIDTH-1:0]  q_o
);

  localparam int SW = DATA_WIDTH + 1;

  logic signed [SW-1:0] s;
  logic signed [SW-1:0] rnd;
  logic signed [SW-1:0] r;

  always_comb begin
    s = $signed({psum_i[DATA_WIDTH-1], psum_i});
    if (relu_i && s < 0) s = '0;
    rnd = '0;
    r = s;
    if (shift_i != '0) begin
      rnd = {{DATA_WIDTH{1'b0}}, 1'b1} << (shift_i - 5'd1);
      r = (s + rnd) >>> shift_i;
    end
    q_o = r[BIT_WIDTH-1:0];
    if (relu_i) begin
      if (r > SW'(SAT_U_MAX)) q_o = BIT_WIDTH'(SAT_U_MAX);
    end else begin
      if (r > SW'(SAT_S_MAX)) q_o = BIT_WIDTH'(SAT_S_MAX);
      else if (r < SW'(SAT_S_MIN)) q_o = BIT_WIDTH'(SAT_S_MIN);
    end
  end

endmodule

// File: rtl/psum_output_packer.sv
// Streams psums out of BRAM, requantises them to bytes and
// packs four per word into the output feature-map BRAM.
module psum_output_packer
  import psum_output_packer_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_BYTE   = 4,
  parameter int BIT_WIDTH  = 8,
  parameter int REG_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_WIDTH-1:0]  i_conf_ppctrl,
  input  logic [REG_WIDTH-1:0]  i_conf_outputsize,
  output logic [REG_WIDTH-1:0]  o_conf_ppstatus,
  output logic [ADDR_WIDTH-1:0] mem_addr_r,
  input  logic [DATA_WIDTH-1:0] mem_odat_r,
  output logic                  mem_enb_r,
  output logic                  mem_rst_r,
  output logic [ADDR_WIDTH-1:0] mem_addr_w,
  output logic [DATA_WIDTH-1:0] mem_idat_w,
  output logic [NUM_BYTE-1:0]   mem_wren_w,
  output logic                  mem_enb_w,
  output logic                  mem_rst_w
);

  localparam int LW = (NUM_BYTE > 1) ? $clog2(NUM_BYTE) : 1;

  state_e state_q, state_d;

  logic                  start_q;
  logic                  start_edge;
  logic                  launch;
  logic                  relu_q;
  logic [SHIFT_W-1:0]    shift_q;
  logic [ADDR_WIDTH-1:0] last_q;
  logic [ADDR_WIDTH-1:0] rd_addr_q;
  logic                  rd_en_q;
  logic                  rd_last;
  logic                  v1_q;
  logic                  l1_q;
  logic [LW-1:0]         lane1_q;
  logic [BIT_WIDTH-1:0]  qbyte;
  logic [DATA_WIDTH-1:0] pack_q, pack_d;
  logic [NUM_BYTE-1:0]   mask_d;
  logic                  wr_fire;
  logic                  we_q;
  logic                  last_wr_q;
  logic [NUM_BYTE-1:0]   wren_q;
  logic [DATA_WIDTH-1:0] wd_q;
  logic [ADDR_WIDTH-1:0] wa_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic                  done_q;
  logic [STAT_CNT_W-1:0] cnt_q;
  logic                  busy;
  logic                  unused_ppctrl;

  assign unused_ppctrl = ^{i_conf_ppctrl[REG_WIDTH-1:CTRL_SHIFT_LO+SHIFT_W],
                           i_conf_ppctrl[CTRL_SHIFT_LO-1:CTRL_RELU+1]};

  assign start_edge = i_conf_ppctrl[CTRL_START] & ~start_q;
  assign launch     = (state_q == ST_IDLE) && start_edge;
  assign rd_last    = rd_en_q && (rd_addr_q == last_q);
  assign wr_fire    = v1_q && (l1_q || lane1_q == LW'(NUM_BYTE - 1));
  assign busy       = (state_q == ST_RUN) || (state_q == ST_DRAIN);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start_edge) state_d = ST_RUN;
      ST_RUN:   if (rd_last) state_d = ST_DRAIN;
      ST_DRAIN: if (last_wr_q) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      start_q   <= 1'b0;
      relu_q    <= 1'b0;
      shift_q   <= '0;
      last_q    <= '0;
      rd_addr_q <= '0;
      rd_en_q   <= 1'b0;
      done_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q <= state_d;
      start_q <= i_conf_ppctrl[CTRL_START];
      if (launch) begin
        relu_q    <= i_conf_ppctrl[CTRL_RELU];
        shift_q   <= i_conf_ppctrl[CTRL_SHIFT_LO +: SHIFT_W];
        last_q    <= i_conf_outputsize[ADDR_WIDTH-1:0];
        rd_addr_q <= '0;
        rd_en_q   <= 1'b1;
        done_q    <= 1'b0;
      end else if (state_q == ST_RUN) begin
        rd_en_q <= ~rd_last;
        if (!rd_last) rd_addr_q <= rd_addr_q + ADDR_WIDTH'(1);
      end
      if (state_q == ST_DRAIN && state_d == ST_DONE) begin
        done_q <= 1'b1;
        cnt_q  <= wr_addr_q[STAT_CNT_W-1:0];
      end
    end
  end

  psum_output_packer_requant #(
    .DATA_WIDTH (DATA_WIDTH),
    .BIT_WIDTH  (BIT_WIDTH)
  ) u_requant (
    .psum_i  (mem_odat_r),
    .relu_i  (relu_q),
    .shift_i (shift_q),
    .q_o     (qbyte)
  );

  // lane 0 starts a fresh word so unwritten lanes read as zero
  always_comb begin
    pack_d = (lane1_q == '0) ? '0 : pack_q;
    mask_d = '0;
    for (int i = 0; i < NUM_BYTE; i++) begin
      if (lane1_q == LW'(i)) pack_d[i*BIT_WIDTH +: BIT_WIDTH] = qbyte;
      mask_d[i] = (LW'(i) <= lane1_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q      <= 1'b0;
      l1_q      <= 1'b0;
      lane1_q   <= '0;
      pack_q    <= '0;
      we_q      <= 1'b0;
      last_wr_q <= 1'b0;
      wren_q    <= '0;
      wd_q      <= '0;
      wa_q      <= '0;
      wr_addr_q <= '0;
    end else begin
      v1_q      <= rd_en_q;
      l1_q      <= rd_last;
      lane1_q   <= rd_addr_q[LW-1:0];
      we_q      <= wr_fire;
      last_wr_q <= wr_fire & l1_q;
      wren_q    <= wr_fire ? mask_d : '0;
      if (v1_q) pack_q <= pack_d;
      if (launch) begin
        wr_addr_q <= '0;
      end else if (wr_fire) begin
        wd_q      <= pack_d;
        wa_q      <= wr_addr_q;
        wr_addr_q <= wr_addr_q + ADDR_WIDTH'(1);
      end
    end
  end

  always_comb begin
    o_conf_ppstatus = '0;
    o_conf_ppstatus[STAT_BUSY] = busy;
    o_conf_ppstatus[STAT_DONE] = done_q;
    o_conf_ppstatus[STAT_CNT_LO +: STAT_CNT_W] = cnt_q;
  end

  assign mem_addr_r = rd_addr_q;
  assign mem_enb_r  = rd_en_q;
  assign mem_rst_r  = 1'b0;
  assign mem_addr_w = wa_q;
  assign mem_idat_w = wd_q;
  assign mem_wren_w = wren_q;
  assign mem_enb_w  = we_q;
  assign mem_rst_w  = 1'b0;

endmodule

// File: tb/tb_psum_output_packer.sv
// Bench for psum_output_packer: vector table + scoreboard of
// expected BRAM writes, plus timing and reset corner sequences.
module tb_psum_output_packer;

  typedef struct {
    int                 n;
    logic [0:7][31:0]   ps;
    bit                 relu;
    int                 sh;
    logic [31:0]        w0;
    logic [3:0]         m0;
    logic [31:0]        w1;
    logic [3:0]         m1;
    int                 nw;
  } vec_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  m;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ppctrl;
  logic [31:0] osize;
  logic [31:0] status;
  logic [31:0] addr_r;
  logic [31:0] odat_r;
  logic        enb_r;
  logic        rst_r;
  logic [31:0] addr_w;
  logic [31:0] idat_w;
  logic [3:0]  wren_w;
  logic        enb_w;
  logic        rst_w;

  logic [31:0] pmem [0:255];
  wr_t         sb [$];
  wr_t         mon_e;
  vec_t        tbl [8];
  int          n_chk = 0;
  int          n_pass = 0;

  psum_output_packer dut (
    .clk               (clk),
    .rst               (rst),
    .i_conf_ppctrl     (ppctrl),
    .i_conf_outputsize (osize),
    .o_conf_ppstatus   (status),
    .mem_addr_r        (addr_r),
    .mem_odat_r        (odat_r),
    .mem_enb_r         (enb_r),
    .mem_rst_r         (rst_r),
    .mem_addr_w        (addr_w),
    .mem_idat_w        (idat_w),
    .mem_wren_w        (wren_w),
    .mem_enb_w         (enb_w),
    .mem_rst_w         (rst_w)
  );

  always #5 clk = ~clk;

  initial odat_r = '0;
  always @(posedge clk)
    if (enb_r) odat_r <= pmem[addr_r[7:0]];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  always @(negedge clk) begin
    if (!rst && enb_w) begin
      if (sb.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_write: addr %h data %h wren %b",
                 addr_w, idat_w, wren_w);
      end else begin
        mon_e = sb.pop_front();
        chk("wr_addr", addr_w, mon_e.a);
        chk("wr_data", idat_w, mon_e.d);
        chk("wr_wren", {28'b0, wren_w}, {28'b0, mon_e.m});
      end
    end
  end

  function automatic vec_t mk(int n, logic [0:7][31:0] ps, bit relu,
                              int sh, logic [31:0] w0, logic [3:0] m0,
                              logic [31:0] w1, logic [3:0] m1, int nw);
    vec_t v;
    v.n = n; v.ps = ps; v.relu = relu; v.sh = sh;
    v.w0 = w0; v.m0 = m0; v.w1 = w1; v.m1 = m1; v.nw = nw;
    return v;
  endfunction

  task automatic load(input vec_t v);
    for (int i = 0; i < 8; i++) pmem[i] = v.ps[i];
    sb.push_back('{32'd0, v.w0, v.m0});
    if (v.nw > 1) sb.push_back('{32'd1, v.w1, v.m1});
  endtask

  task automatic go(input vec_t v);
    ppctrl = '0;
    ppctrl[0] = 1'b1;
    ppctrl[1] = v.relu;
    ppctrl[12:8] = v.sh[4:0];
    osize = 32'(v.n);
  endtask

  task automatic run_vec(input vec_t v);
    load(v);
    @(negedge clk);
    go(v);
    @(negedge clk);
    chk("rd_addr0", addr_r, 32'd0);
    chk("rd_en0", {31'b0, enb_r}, 32'd1);
    chk("done_clr", {31'b0, status[1]}, 32'd0);
    for (int k = 0; k < 200 && !status[1]; k++) @(negedge clk);
    chk("done", {31'b0, status[1]}, 32'd1);
    chk("busy_lo", {31'b0, status[0]}, 32'd0);
    chk("wcount", {16'b0, status[31:16]}, 32'(v.nw));
    chk("sb_empty", 32'(sb.size()), 32'd0);
    sb.delete();
    ppctrl[0] = 1'b0;
    @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_addr_r"}, addr_r, 32'd0);
    chk({tag, "_enb_r"}, {31'b0, enb_r}, 32'd0);
    chk({tag, "_addr_w"}, addr_w, 32'd0);
    chk({tag, "_idat_w"}, idat_w, 32'd0);
    chk({tag, "_wren_w"}, {28'b0, wren_w}, 32'd0);
    chk({tag, "_enb_w"}, {31'b0, enb_w}, 32'd0);
    chk({tag, "_status"}, status, 32'd0);
    chk({tag, "_rst_rw"}, {30'b0, rst_r, rst_w}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t3, tw0, tlast, tdone, nrd;
    bit found;
    rst = 1'b1;
    ppctrl = '0;
    osize = '0;
    for (int i = 0; i < 256; i++) pmem[i] = '0;

    tbl[0] = mk(7, {32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8},
                1, 0, 32'h04030201, 4'hF, 32'h08070605, 4'hF, 2);
    tbl[1] = mk(3, {32'd383, 32'd384, 32'd100000, 32'(-5),
                    32'd0, 32'd0, 32'd0, 32'd0},
                0, 8, 32'h007F0201, 4'hF, 32'h0, 4'h0, 1);
    tbl[2] = mk(3, {32'(-1000), 32'd70000, 32'(-1), 32'd255,
                    32'd0, 32'd0, 32'd0, 32'd0},
                1, 0, 32'hFF00FF00, 4'hF, 32'h0, 4'h0, 1);
    tbl[3] = mk(5, {32'd10, 32'd20, 32'd30, 32'd40, 32'd50, 32'd60,
                    32'd0, 32'd0},
                0, 0, 32'h281E140A, 4'hF, 32'h00003C32, 4'h3, 2);
    tbl[4] = mk(0, {32'(-3), 32'd9, 32'd9, 32'd9, 32'd9, 32'd9, 32'd9, 32'd9},
                0, 0, 32'h000000FD, 4'h1, 32'h0, 4'h0, 1);
    tbl[5] = mk(2, {32'h7FFFFFFF, 32'h80000000, 32'(-7),
                    32'd0, 32'd0, 32'd0, 32'd0, 32'd0},
                0, 0, 32'h00F9807F, 4'h7, 32'h0, 4'h0, 1);
    tbl[6] = mk(1, {32'h7FFFFFFF, 32'h80000000,
                    32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0},
                0, 31, 32'h0000FF01, 4'h3, 32'h0, 4'h0, 1);
    tbl[7] = mk(3, {32'(-300), 32'd1000, 32'd2000, 32'd65535,
                    32'd0, 32'd0, 32'd0, 32'd0},
                1, 3, 32'hFFFA7D00, 4'hF, 32'h0, 4'h0, 1);

    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 8; v++) run_vec(tbl[v]);

    // pipeline timing, mid-run restart and config change ignored
    load(tbl[0]);
    @(negedge clk);
    go(tbl[0]);
    t3 = -1; tw0 = -1; tlast = -1; tdone = -1; nrd = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (enb_r) begin
        nrd++;
        chk("rd_addr_seq", addr_r, 32'(c - 1));
        if (addr_r == 32'd3) t3 = c;
      end
      if (enb_w && addr_w == 32'd0) tw0 = c;
      if (enb_w && addr_w == 32'd1) tlast = c;
      if (status[1] && tdone < 0) tdone = c;
      if (c == 3) ppctrl[0] = 1'b0;
      if (c == 4) begin
        ppctrl[0] = 1'b1;
        osize = 32'd2;
      end
    end
    chk("rd_count", 32'(nrd), 32'd8);
    chk("wr_latency", 32'(tw0), 32'(t3 + 2));
    chk("done_latency", 32'(tdone), 32'(tlast + 1));
    chk("t_wcount", {16'b0, status[31:16]}, 32'd2);
    chk("held_no_retrig", {31'b0, enb_r}, 32'd0);
    chk("t_sb_empty", 32'(sb.size()), 32'd0);
    sb.delete();
    ppctrl = '0;
    osize = '0;
    @(negedge clk);

    // reset in the middle of a long run
    for (int i = 0; i < 256; i++) pmem[i] = 32'(i);
    for (int k = 0; k < 24; k++)
      sb.push_back('{32'(k), {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)},
                     4'hF});
    @(negedge clk);
    osize = 32'd49283;
    ppctrl = 32'h1;
    found = 1'b0;
    for (int k = 0; k < 300 && !found; k++) begin
      @(negedge clk);
      if (enb_r && addr_r == 32'd100) found = 1'b1;
    end
    chk("reach_n100", {31'b0, found}, 32'd1);
    rst = 1'b1;
    #1;
    chk_zero("midrst");
    chk("midrst_sb", 32'(sb.size()), 32'd0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    ppctrl = '0;
    osize = '0;
    repeat (3) @(negedge clk);
    chk("post_rst_idle", {31'b0, enb_r, enb_w}, 32'd0);
    run_vec(tbl[0]);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
